sprite_pipe_mapper: RTL

SPRITE_PIPE_MAPPER -- requirements
Module: sprite_pipe_mapper

---
 rtl/sprite_pipe_mapper_if.sv | 41 ++++
 rtl/sprite_pipe_mapper.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sprite_pipe_mapper_if.sv
// Pixel-stream, sprite-ROM and colour-output bundle for the sprite pipeline.
// The master side feeds pixels and game state; the slave side is the mapper.
interface sprite_pipe_mapper_if #(
    parameter int NUM_GHOSTS = 4,
    parameter int SPRITE_W   = 16
);
    logic                             frame_start;
    logic                             pix_valid;
    logic [9:0]                       DrawX;
    logic [9:0]                       DrawY;
    logic                             wall_pix;
    logic                             dot_pix;
    logic [9:0]                       pac_x;
    logic [9:0]                       pac_y;
    logic [1:0]                       pac_dir;
    logic                             pac_moving;
    logic [10*NUM_GHOSTS-1:0]         ghost_x;
    logic [10*NUM_GHOSTS-1:0]         ghost_y;
    logic                             frightened;
    logic                             fright_ending;
    logic [8*(NUM_GHOSTS+1)-1:0]      spr_addr;
    logic [SPRITE_W*(NUM_GHOSTS+1)-1:0] spr_row;
    logic [7:0]                       Red;
    logic [7:0]                       Green;
    logic [7:0]                       Blue;
    logic                             rgb_valid;

    modport master (
        output frame_start, pix_valid, DrawX, DrawY, wall_pix, dot_pix,
               pac_x, pac_y, pac_dir, pac_moving, ghost_x, ghost_y,
               frightened, fright_ending, spr_row,
        input  spr_addr, Red, Green, Blue, rgb_valid
    );

    modport slave (
        input  frame_start, pix_valid, DrawX, DrawY, wall_pix, dot_pix,
               pac_x, pac_y, pac_dir, pac_moving, ghost_x, ghost_y,
               frightened, fright_ending, spr_row,
        output spr_addr, Red, Green, Blue, rgb_valid
    );
endinterface

// File: rtl/sprite_pipe_mapper.sv
// Two-stage pixel mapper: stage 0 does hit tests and sprite-ROM addressing,
// stage 1 picks the sprite bit, resolves layer priority and drives RGB.
module sprite_pipe_mapper #(
    parameter int NUM_GHOSTS   = 4,
    parameter int SPRITE_W     = 16,
    parameter int CHOMP_FRAMES = 8,
    parameter int BLINK_FRAMES = 16,
    // Ghost 0 (red) sits in the least significant 24 bits.
    parameter logic [24*NUM_GHOSTS-1:0] GHOST_RGB =
        {24'hFFB851, 24'h00FFFF, 24'hFFB8FF, 24'hFF0000}
) (
    input  logic               Clk,
    input  logic               Reset_n,
    sprite_pipe_mapper_if.slave bus
);
    localparam int CH  = NUM_GHOSTS + 1;
    localparam int CW  = $clog2(SPRITE_W);
    localparam int CCW = $clog2(CHOMP_FRAMES + 1);
    localparam int BCW = $clog2(BLINK_FRAMES + 1);

    logic [CCW-1:0]    chomp_cnt_reg;
    logic              phase_reg;
    logic [BCW-1:0]    blink_cnt_reg;
    logic              blink_reg;

    logic [CH-1:0]     hit_next;
    logic [CW-1:0]     col_next [CH];
    logic [7:0]        addr_next [CH];
    logic [CH-1:0]     hit_reg;
    logic [CW-1:0]     col_reg [CH];
    logic [8*CH-1:0]   spr_addr_reg;
    logic              valid_s0_reg, wall_s0_reg, dot_s0_reg;
    logic              fright_s0_reg, ending_s0_reg, blink_s0_reg;

    logic [CH-1:0]     on_pix;
    logic [23:0]       ghost_colour [NUM_GHOSTS];
    logic [23:0]       colour_next;
    logic [7:0]        red_reg, green_reg, blue_reg;
    logic              rgb_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_chan
            logic [9:0]          obj_x, obj_y;
            logic [10:0]         dx, dy;
            logic [SPRITE_W-1:0] row_bits;

            // 11-bit differences keep objects near 1023 from wrapping onto x/y=0.
            assign dx = {1'b0, bus.DrawX} - {1'b0, obj_x};
            assign dy = {1'b0, bus.DrawY} - {1'b0, obj_y};
            assign hit_next[gi] = (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_W));
            assign col_next[gi] = dx[CW-1:0];
            assign row_bits     = bus.spr_row[gi*SPRITE_W +: SPRITE_W];
            assign on_pix[gi]   = hit_reg[gi] & row_bits[col_reg[gi]];

            if (gi == 0) begin : g_pac
                assign obj_x = bus.pac_x;
                assign obj_y = bus.pac_y;
                assign addr_next[gi] = 8'(({phase_reg, bus.pac_dir} * SPRITE_W) + dy[CW-1:0]);
            end else begin : g_ghost
                assign obj_x = bus.ghost_x[(gi-1)*10 +: 10];
                assign obj_y = bus.ghost_y[(gi-1)*10 +: 10];
                assign addr_next[gi] = 8'(((bus.frightened ? 12 : 8) * SPRITE_W) + dy[CW-1:0]);
            end
        end

        for (gi = 0; gi < NUM_GHOSTS; gi++) begin : g_gcol
            assign ghost_colour[gi] = !fright_s0_reg ? GHOST_RGB[gi*24 +: 24] :
                                      (ending_s0_reg && blink_s0_reg) ? 24'hFFFFFF : 24'h2121FF;
        end
    endgenerate

    // Mode flags and blink are captured alongside the pixel so a frame_start
    // or mode change in the same cycle cannot alter pixels already in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_reg       <= '0;
            spr_addr_reg  <= '0;
            for (int i = 0; i < CH; i++) col_reg[i] <= '0;
            valid_s0_reg  <= 1'b0;
            wall_s0_reg   <= 1'b0;
            dot_s0_reg    <= 1'b0;
            fright_s0_reg <= 1'b0;
            ending_s0_reg <= 1'b0;
            blink_s0_reg  <= 1'b0;
        end else begin
            hit_reg <= hit_next;
            for (int i = 0; i < CH; i++) begin
                col_reg[i]               <= col_next[i];
                spr_addr_reg[i*8 +: 8]   <= addr_next[i];
            end
            valid_s0_reg  <= bus.pix_valid;
            wall_s0_reg   <= bus.wall_pix;
            dot_s0_reg    <= bus.dot_pix;
            fright_s0_reg <= bus.frightened;
            ending_s0_reg <= bus.fright_ending;
            blink_s0_reg  <= blink_reg;
        end
    end

    assign bus.spr_addr = spr_addr_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            chomp_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
        end else begin
            if (bus.frame_start && bus.pac_moving) begin
                if (chomp_cnt_reg == CCW'(CHOMP_FRAMES - 1)) begin
                    chomp_cnt_reg <= '0;
                    phase_reg     <= ~phase_reg;
                end else begin
                    chomp_cnt_reg <= chomp_cnt_reg + 1'b1;
                end
            end
            if (!bus.fright_ending) begin
                blink_cnt_reg <= '0;
                blink_reg     <= 1'b0;
            end else if (bus.frame_start) begin
                if (blink_cnt_reg == BCW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_reg <= '0;
                    blink_reg     <= ~blink_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Lowest priority is applied first so later overrides win.
    always_comb begin
        colour_next = 24'h000000;
        if (wall_s0_reg) colour_next = 24'h0000FF;
        if (dot_s0_reg)  colour_next = 24'hFFFF00;
        for (int i = NUM_GHOSTS; i >= 1; i--) begin
            if (on_pix[i]) colour_next = ghost_colour[i-1];
        end
        if (on_pix[0]) colour_next = 24'hFFFF00;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red_reg       <= '0;
            green_reg     <= '0;
            blue_reg      <= '0;
            rgb_valid_reg <= 1'b0;
        end else if (valid_s0_reg) begin
            red_reg       <= colour_next[23:16];
            green_reg     <= colour_next[15:8];
            blue_reg      <= colour_next[7:0];
            rgb_valid_reg <= 1'b1;
        end else begin
            red_reg       <= '0;
            green_reg     <= '0;
            blue_reg      <= '0;
            rgb_valid_reg <= 1'b0;
        end
    end

    assign bus.Red       = red_reg;
    assign bus.Green     = green_reg;
    assign bus.Blue      = blue_reg;
    assign bus.rgb_valid = rgb_valid_reg;
endmodule
